rf_write_sched: RTL and testbench
=================================

# rf_write_sched

Register-file write scheduler and issue interlock for the RI5CY-style core. It sits beside the ID stage, between decode and the register bank.
- Keeps a 32-entry busy scoreboard and stalls issue on RAW/WAW hazards.
- Sequences the fixed-latency multiply/divide unit (MDU).
- Arbitrates the single register-bank write port between the in-order WB path and MDU results.

## Interface
- `ADDR_WIDTH`, 5, register address width
- `NUM_REGS`, 32, architectural registers (2**ADDR_WIDTH)
- `MDU_LAT`, 4, MDU cycles from start to result valid (≥1)
- `clk` in 1 — core clock
- `rst` in 1 — synchronous, active-high reset
- `issue_valid_i` in 1 — decoded instruction present in ID
- `issue_rs1_i` / `issue_rs2_i` in ADDR_WIDTH — source addresses
- `issue_use_rs2_i` in 1 — instruction reads rs2
- `issue_rd_i` in ADDR_WIDTH — destination address
- `issue_wen_i` in 1 — instruction writes rd
- `issue_mdu_i` in 1 — instruction is an MDU op (`mdu_ctrl_o` from control unit)
- `stall_o` out 1 — hold ID/IF; issue accepted iff `issue_valid_i & ~stall_o`
- `mdu_start_o` out 1 — one-cycle pulse launching the MDU
- `wb_valid_i` in 1 — WB path requests a write
- `wb_addr_i` in ADDR_WIDTH — WB destination
- `rf_wen_o` out 1 — register-bank write enable
- `rf_waddr_o` out ADDR_WIDTH — register-bank write address
- `rf_wsel_o` out 1 — write-data mux select: 0 = WB data, 1 = MDU result register
- `mdu_capture_o` out 1 — latch MDU result into the hold register this cycle

## Operation
- **Scoreboard:** `busy[NUM_REGS]`; `busy[0]` is hardwired to 0.
  - Set at accept when `issue_wen_i` and rd≠0.
  - Cleared on the cycle `rf_wen_o` commits that address.
- **stall_o** is high when `issue_valid_i` and any of the following holds:
  - `busy[rs1]`
  - `use_rs2 & busy[rs2]`
  - `wen & busy[rd]` (WAW)
  - `issue_mdu_i` and MDU FSM ≠ IDLE
  - MDU FSM = HOLD (forces the WB path to drain)
- The hazard check uses registered busy bits. There is no bypass in the commit cycle.
- **MDU FSM:**
  - IDLE: an accepted MDU op drives `mdu_start_o`=1, latches rd into `mdu_rd`, loads `cnt`=MDU_LAT-1, then goes to RUN.
  - RUN: `cnt` decrements; at `cnt`==0, `mdu_capture_o`=1, then goes to HOLD.
  - HOLD: if `~wb_valid_i`, then `rf_wen_o`=1, `rf_wsel_o`=1, `rf_waddr_o`=`mdu_rd`, then goes to IDLE. Otherwise it remains in HOLD.
- **Write-port arbitration:**
  - The WB path has fixed priority: `rf_wen_o`=`wb_valid_i`, `rf_waddr_o`=`wb_addr_i`, `rf_wsel_o`=0.
  - The MDU writes only in HOLD with the port free.
  - Starvation is bounded because HOLD stalls issue, so WB drains within pipeline depth.
- A WB write to x0 drives `rf_wen_o` but clears nothing.
- MDU ops with rd=x0 still run and commit, with a harmless write.
- **Reset:** busy all 0, FSM IDLE, `cnt`=0, `mdu_rd`=0. All outputs are 0 during and after reset until stimulus arrives.
- **Reset mid-RUN/HOLD:** the pending MDU result is discarded with no write.

## Timing
- The scoreboard-set to stall effect is visible the cycle after accept.
- A clear at commit edge N lets a dependent instruction issue at N+1.
- For an MDU op accepted at cycle T:
  - `mdu_start_o` is high at T.
  - `mdu_capture_o` is high at T+MDU_LAT.
  - The earliest commit is T+MDU_LAT+1.
  - Its rd busy clears after that edge.
- All outputs are combinational from registered state plus current inputs. There is no combinational path from `wb_*` to `stall_o`.

## Configuration
- `RF_SCHED_MDU_EN` defined: full behaviour described above.
- Undefined:
  - The MDU FSM, counter and `mdu_rd` are removed.
  - `mdu_start_o`, `mdu_capture_o` and `rf_wsel_o` are tied to 0.
  - `issue_mdu_i` is ignored; such instructions are scoreboarded as ordinary WB writers.

## Structure
- **Shared package:** `mdu_state_e` (IDLE/RUN/HOLD) and the ADDR_WIDTH/NUM_REGS defaults, alongside the existing `riscv_defines` constants.
- **Sub-module:** `scoreboard` holds the busy vector, set/clear ports and three lookup outputs. The top level contains the FSM and arbiter.

## Test plan
- **RAW:** issue `add x5` (wen), then next cycle `sub` reading x5. `stall_o`=1 until WB commits x5 at cycle N; `sub` accepted at N+1.
- **WAW / x0:** issue two back-to-back writes to x0. No stall. `busy[0]` stays 0.
- **MDU latency (MDU_LAT=4):** `mul x7` accepted at T=10. `mdu_start_o`@10, `mdu_capture_o`@14, commit `rf_wsel_o`=1 addr 7 @15.
- **Port conflict:** MDU in HOLD while `wb_valid_i`=1 for 3 cycles (addr 3). Three WB commits come first and `stall_o`=1 throughout; the MDU commits on the 4th cycle.
- **Second MDU while busy:** second `mul` held with `stall_o`=1 until the FSM returns to IDLE.
- **Reset during RUN:** assert `rst` at T+2. No `mdu_capture_o` and no `rf_wen_o` afterwards; busy all 0; a new `mul` is accepted immediately.

Source files
------------

// File: rtl/rf_write_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_sched_pkg
// Description : Shared defaults and MDU sequencer state encoding for the
//               register-file write scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package rf_write_sched_pkg;

    localparam int c_ADDR_WIDTH = 5;
    localparam int c_NUM_REGS   = 32;
    localparam int c_MDU_LAT    = 4;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_HOLD = 2'd2
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_write_sched_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_sched_scoreboard
// Description : Per-register busy bits with set/clear ports and three
//               lookups; x0 is never busy.
// Revision    : 1.0  initial release
// ============================================================================
module rf_write_sched_scoreboard
    import rf_write_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int NUM_REGS   = c_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_en,
    input  logic [ADDR_WIDTH-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_rd_busy
);

    logic [NUM_REGS-1:1] r_busy;
    logic [NUM_REGS-1:0] w_busy;

    // A set wins over a clear of the same register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (i_set_en && (i_set_addr == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (i_clr_en && (i_clr_addr == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign w_busy     = {r_busy, 1'b0};
    assign o_rs1_busy = w_busy[i_rs1_addr];
    assign o_rs2_busy = w_busy[i_rs2_addr];
    assign o_rd_busy  = w_busy[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/rf_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_sched
// Description : Issue interlock, MDU sequencer and register-bank write-port
//               arbiter. MDU support is built only when RF_SCHED_MDU_EN is
//               defined; otherwise MDU ops are plain WB writers.
// Revision    : 1.0  initial release
// ============================================================================
module rf_write_sched
    import rf_write_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int NUM_REGS   = c_NUM_REGS,
    parameter int MDU_LAT    = c_MDU_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rs1_i,
    input  logic [ADDR_WIDTH-1:0] issue_rs2_i,
    input  logic                  issue_use_rs2_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic                  issue_wen_i,
    input  logic                  issue_mdu_i,
    output logic                  stall_o,
    output logic                  mdu_start_o,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    output logic                  rf_wen_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic                  rf_wsel_o,
    output logic                  mdu_capture_o
);

    logic w_rs1_busy;
    logic w_rs2_busy;
    logic w_rd_busy;
    logic w_hazard;
    logic w_accept;
    logic w_set_en;

    assign w_hazard = w_rs1_busy | (issue_use_rs2_i & w_rs2_busy) | (issue_wen_i & w_rd_busy);
    assign w_accept = issue_valid_i & ~stall_o;
    assign w_set_en = w_accept & issue_wen_i & (issue_rd_i != '0);

    rf_write_sched_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_set_en),
        .i_set_addr (issue_rd_i),
        .i_clr_en   (rf_wen_o),
        .i_clr_addr (rf_waddr_o),
        .i_rs1_addr (issue_rs1_i),
        .i_rs2_addr (issue_rs2_i),
        .i_rd_addr  (issue_rd_i),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy),
        .o_rd_busy  (w_rd_busy)
    );

`ifdef RF_SCHED_MDU_EN
    localparam int c_CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    mdu_state_e            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [ADDR_WIDTH-1:0] r_mdu_rd;
    logic                  w_in_hold;

    assign w_in_hold = (r_state == MDU_HOLD);

    // HOLD blocks all issue so the WB path drains and the MDU result gets the port.
    assign stall_o       = issue_valid_i & (w_hazard | (issue_mdu_i & (r_state != MDU_IDLE)) | w_in_hold);
    assign mdu_start_o   = w_accept & issue_mdu_i;
    assign mdu_capture_o = (r_state == MDU_RUN) && (r_cnt == '0);
    assign rf_wen_o      = wb_valid_i | w_in_hold;
    assign rf_waddr_o    = wb_valid_i ? wb_addr_i : r_mdu_rd;
    assign rf_wsel_o     = ~wb_valid_i & w_in_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= MDU_IDLE;
            r_cnt    <= '0;
            r_mdu_rd <= '0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (mdu_start_o) begin
                        r_mdu_rd <= issue_rd_i;
                        r_cnt    <= c_CNT_W'(MDU_LAT - 1);
                        r_state  <= MDU_RUN;
                    end
                end
                MDU_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= MDU_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                MDU_HOLD: begin
                    if (!wb_valid_i) begin
                        r_state <= MDU_IDLE;
                    end
                end
                default: r_state <= MDU_IDLE;
            endcase
        end
    end
`else
    logic w_unused_mdu;

    assign w_unused_mdu  = issue_mdu_i & (MDU_LAT > 0);
    assign stall_o       = issue_valid_i & w_hazard;
    assign mdu_start_o   = 1'b0;
    assign mdu_capture_o = 1'b0;
    assign rf_wen_o      = wb_valid_i;
    assign rf_waddr_o    = wb_addr_i;
    assign rf_wsel_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_sched
// Description : Self-checking bench: interlock vector table, write-port
//               scoreboard queue and MDU corner-case sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rf_write_sched;

    localparam int c_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid_i;
    logic [4:0] issue_rs1_i;
    logic [4:0] issue_rs2_i;
    logic       issue_use_rs2_i;
    logic [4:0] issue_rd_i;
    logic       issue_wen_i;
    logic       issue_mdu_i;
    logic       stall_o;
    logic       mdu_start_o;
    logic       wb_valid_i;
    logic [4:0] wb_addr_i;
    logic       rf_wen_o;
    logic [4:0] rf_waddr_o;
    logic       rf_wsel_o;
    logic       mdu_capture_o;

    rf_write_sched #(
        .ADDR_WIDTH (5),
        .NUM_REGS   (32),
        .MDU_LAT    (c_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid_i   (issue_valid_i),
        .issue_rs1_i     (issue_rs1_i),
        .issue_rs2_i     (issue_rs2_i),
        .issue_use_rs2_i (issue_use_rs2_i),
        .issue_rd_i      (issue_rd_i),
        .issue_wen_i     (issue_wen_i),
        .issue_mdu_i     (issue_mdu_i),
        .stall_o         (stall_o),
        .mdu_start_o     (mdu_start_o),
        .wb_valid_i      (wb_valid_i),
        .wb_addr_i       (wb_addr_i),
        .rf_wen_o        (rf_wen_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wsel_o       (rf_wsel_o),
        .mdu_capture_o   (mdu_capture_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wsel;
        logic [4:0] addr;
    } wr_t;

    typedef struct {
        bit       iv;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       use2;
        bit [4:0] rd;
        bit       wen;
        bit       wbv;
        bit [4:0] wba;
        bit       exp_stall;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input bit iv, input bit [4:0] rs1, input bit [4:0] rs2, input bit use2,
                         input bit [4:0] rd, input bit wen, input bit mdu);
        issue_valid_i   = iv;
        issue_rs1_i     = rs1;
        issue_rs2_i     = rs2;
        issue_use_rs2_i = use2;
        issue_rd_i      = rd;
        issue_wen_i     = wen;
        issue_mdu_i     = mdu;
    endtask

    task automatic wb(input bit v, input bit [4:0] a);
        wb_valid_i = v;
        wb_addr_i  = a;
        if (v) exp_q.push_back({1'b0, a});
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
    endtask

    // Let combinational outputs settle, then check any write-port commit against the queue.
    task automatic settle();
        wr_t e;
        #1;
        if (rf_wen_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(rf_waddr_o), int'(e.addr));
                chk("wr_sel", int'(rf_wsel_o), int'(e.wsel));
            end
        end
    endtask

    task automatic addv(input bit iv, input bit [4:0] rs1, input bit [4:0] rs2, input bit use2,
                        input bit [4:0] rd, input bit wen, input bit wbv, input bit [4:0] wba,
                        input bit st);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2; v.rd = rd; v.wen = wen;
        v.wbv = wbv; v.wba = wba; v.exp_stall = st;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        settle();
        chk("rst_stall", int'(stall_o), 0);
        chk("rst_wen", int'(rf_wen_o), 0);
        chk("rst_waddr", int'(rf_waddr_o), 0);
        chk("rst_wsel", int'(rf_wsel_o), 0);
        chk("rst_start", int'(mdu_start_o), 0);
        chk("rst_capture", int'(mdu_capture_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // iv rs1 rs2 use2 rd wen wbv wba stall
        addv(1, 1, 2, 1, 5, 1, 0, 0, 0);   // add x5
        addv(1, 5, 0, 0, 6, 1, 0, 0, 1);   // sub reads x5: RAW
        addv(0, 5, 0, 0, 6, 1, 0, 0, 0);   // no valid, no stall
        addv(1, 5, 0, 0, 6, 1, 1, 5, 1);   // commit cycle: no bypass
        addv(1, 5, 0, 0, 6, 1, 0, 0, 0);   // sub accepted next cycle
        addv(1, 0, 6, 0, 8, 1, 0, 0, 0);   // rs2 busy but unused
        addv(1, 0, 6, 1, 9, 1, 0, 0, 1);   // rs2 busy and used
        addv(1, 0, 0, 0, 8, 1, 0, 0, 1);   // WAW on x8
        addv(1, 0, 0, 0, 8, 0, 0, 0, 0);   // no write, no WAW
        addv(1, 0, 0, 0, 0, 1, 0, 0, 0);   // write x0
        addv(1, 0, 0, 1, 0, 1, 0, 0, 0);   // write x0 again, x0 never busy
        addv(0, 0, 0, 0, 0, 0, 1, 0, 0);   // WB to x0
        addv(1, 6, 0, 0, 0, 0, 1, 6, 1);   // x6 still registered busy
        addv(1, 0, 6, 1, 9, 1, 0, 0, 0);   // x6 cleared -> issue, x9 busy
        addv(0, 0, 0, 0, 0, 0, 1, 8, 0);
        addv(1, 8, 9, 0, 0, 0, 1, 9, 0);
        addv(1, 9, 8, 1, 0, 0, 0, 0, 0);
        addv(1, 1, 2, 1, 3, 1, 0, 0, 0);
        addv(1, 3, 0, 0, 0, 0, 0, 0, 1);
        addv(0, 0, 0, 0, 0, 0, 1, 3, 0);
        addv(1, 3, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].use2, tbl[i].rd, tbl[i].wen, 1'b0);
            wb(tbl[i].wbv, tbl[i].wba);
            settle();
            chk($sformatf("vec%0d_stall", i), int'(stall_o), int'(tbl[i].exp_stall));
            chk($sformatf("vec%0d_start", i), int'(mdu_start_o), 0);
            @(negedge clk);
        end
        idle();

`ifdef RF_SCHED_MDU_EN
        // MDU latency: mul x7 accepted at T
        drive(1, 1, 2, 1, 7, 1, 1);
        settle();
        chk("mul7_stall", int'(stall_o), 0);
        chk("mul7_start", int'(mdu_start_o), 1);
        @(negedge clk);
        for (int k = 1; k < c_LAT; k++) begin
            drive(1, 7, 0, 0, 0, 0, 0);
            settle();
            chk("mul7_raw_stall", int'(stall_o), 1);
            chk("mul7_run_capture", int'(mdu_capture_o), 0);
            chk("mul7_run_start", int'(mdu_start_o), 0);
            @(negedge clk);
        end
        idle();
        settle();
        chk("mul7_capture", int'(mdu_capture_o), 1);
        exp_q.push_back({1'b1, 5'd7});
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 0);
        settle();
        chk("mul7_hold_stall", int'(stall_o), 1);
        chk("mul7_commit_wen", int'(rf_wen_o), 1);
        @(negedge clk);
        drive(1, 7, 0, 0, 0, 0, 0);
        settle();
        chk("mul7_dep_issue", int'(stall_o), 0);
        @(negedge clk);

        // Second MDU op held while busy, plus WB port conflict in HOLD
        drive(1, 0, 0, 0, 10, 1, 1);
        settle();
        chk("mul10_start", int'(mdu_start_o), 1);
        @(negedge clk);
        drive(1, 0, 0, 0, 11, 1, 1);
        for (int k = 1; k < c_LAT; k++) begin
            settle();
            chk("mul11_held", int'(stall_o), 1);
            chk("mul11_no_start", int'(mdu_start_o), 0);
            @(negedge clk);
        end
        settle();
        chk("mul10_capture", int'(mdu_capture_o), 1);
        chk("mul11_held_cap", int'(stall_o), 1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            wb(1, 3);
            settle();
            chk("conflict_stall", int'(stall_o), 1);
            chk("conflict_wen", int'(rf_wen_o), 1);
            @(negedge clk);
        end
        wb(0, 0);
        exp_q.push_back({1'b1, 5'd10});
        settle();
        chk("mul10_commit_stall", int'(stall_o), 1);
        chk("mul10_commit_wen", int'(rf_wen_o), 1);
        @(negedge clk);
        settle();
        chk("mul11_accept", int'(stall_o), 0);
        chk("mul11_start", int'(mdu_start_o), 1);
        @(negedge clk);
        idle();
        for (int k = 1; k < c_LAT; k++) begin
            settle();
            chk("mul11_run_capture", int'(mdu_capture_o), 0);
            @(negedge clk);
        end
        settle();
        chk("mul11_capture", int'(mdu_capture_o), 1);
        exp_q.push_back({1'b1, 5'd11});
        @(negedge clk);
        settle();
        chk("mul11_commit", int'(rf_wen_o), 1);
        @(negedge clk);

        // Reset two cycles into RUN discards the result
        drive(1, 0, 0, 0, 12, 1, 1);
        settle();
        chk("mul12_start", int'(mdu_start_o), 1);
        @(negedge clk);
        idle();
        settle();
        @(negedge clk);
        rst = 1'b1;
        settle();
        chk("rstrun_wen", int'(rf_wen_o), 0);
        chk("rstrun_capture", int'(mdu_capture_o), 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 12, 0, 0, 13, 1, 1);
        settle();
        chk("mul13_stall", int'(stall_o), 0);
        chk("mul13_start", int'(mdu_start_o), 1);
        @(negedge clk);
        idle();
        for (int k = 1; k < c_LAT; k++) begin
            settle();
            chk("rstrun_no_capture", int'(mdu_capture_o), 0);
            chk("rstrun_no_wen", int'(rf_wen_o), 0);
            @(negedge clk);
        end
        settle();
        chk("mul13_capture", int'(mdu_capture_o), 1);
        exp_q.push_back({1'b1, 5'd13});
        @(negedge clk);
        settle();
        chk("mul13_commit", int'(rf_wen_o), 1);
        @(negedge clk);
`else
        // Without the MDU, MDU ops are ordinary scoreboarded writers
        drive(1, 1, 0, 0, 7, 1, 1);
        settle();
        chk("nomdu7_stall", int'(stall_o), 0);
        chk("nomdu7_start", int'(mdu_start_o), 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 11, 1, 1);
        settle();
        chk("nomdu11_stall", int'(stall_o), 0);
        @(negedge clk);
        drive(1, 7, 0, 0, 0, 0, 0);
        for (int k = 0; k < c_LAT + 1; k++) begin
            settle();
            chk("nomdu_raw7", int'(stall_o), 1);
            chk("nomdu_capture", int'(mdu_capture_o), 0);
            @(negedge clk);
        end
        wb(1, 7);
        settle();
        chk("nomdu_raw7_commit", int'(stall_o), 1);
        @(negedge clk);
        wb(1, 11);
        settle();
        chk("nomdu_raw7_clear", int'(stall_o), 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 20, 1, 0);
        wb(0, 0);
        settle();
        @(negedge clk);
        idle();
        rst = 1'b1;
        settle();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 20, 11, 1, 0, 0, 0);
        settle();
        chk("nomdu_rst_clears", int'(stall_o), 0);
        @(negedge clk);
`endif

        idle();
        settle();
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
